pzcorebus_response_unpacker: RTL and testbench

- Converts wide responses from the upsized master side (MASTER_DATA_WIDTH) back into narrow slave-side beats (SLAVE_DATA_WIDTH). Sits directly downstream of the upsizer master FIFO on the response return, feeding the narrow slave bus.
- Per-request unpack information (start lane, narrow beat count, read/ack type) arrives on a side channel from the request path, in request order.

---
 rtl/pzcorebus_response_unpacker_pkg.sv | 14 +
 rtl/pzcorebus_response_unpacker_fifo.sv | 69 ++++++
 rtl/pzcorebus_response_unpacker.sv | 144 ++++++++++++++
 tb/tb_pzcorebus_response_unpacker.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pzcorebus_response_unpacker_pkg.sv
// Shared types for the corebus response unpacker.
// Holds the holding-register state encoding and the lane-ratio helper.
package pzcorebus_response_unpacker_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } unpack_state_e;

    function automatic int calc_ratio(input int master_width, input int slave_width);
        return master_width / slave_width;
    endfunction

endpackage

// File: rtl/pzcorebus_response_unpacker_fifo.sv
// Synchronous FIFO holding per-request unpack info in request order.
// Besides the head entry it exposes the entry behind it for back-to-back reloads.
module pzcorebus_response_unpacker_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    input  logic             i_pop,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_data,
    output logic [WIDTH-1:0] o_next
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_rd;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;
    logic [PW-1:0]    w_rd_next;
    logic [PW-1:0]    w_wr_next;

    function automatic logic [PW-1:0] incr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_push    = i_push && !o_full;
    assign w_pop     = i_pop && !o_empty;
    assign w_rd_next = incr(r_rd);
    assign w_wr_next = incr(r_wr);
    assign o_data    = r_mem[r_rd];
    // With a single entry the follower is whatever is being pushed now
    assign o_next    = (r_count == CW'(1)) ? i_data : r_mem[w_rd_next];

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wr <= w_wr_next;
            end
            if (w_pop) begin
                r_rd <= w_rd_next;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/pzcorebus_response_unpacker.sv
// Splits wide master-side responses back into narrow slave-side beats.
// Unpack info (start lane, beat count, read/ack) arrives ahead in request order.
module pzcorebus_response_unpacker
    import pzcorebus_response_unpacker_pkg::*;
#(
    parameter int SLAVE_DATA_WIDTH  = 64,
    parameter int MASTER_DATA_WIDTH = 256,
    parameter int LENGTH_WIDTH      = 8,
    parameter int INFO_DEPTH        = 4
) (
    input  logic                                                i_clk,
    input  logic                                                i_rst,
    input  logic                                                i_info_valid,
    output logic                                                o_info_ready,
    input  logic [$clog2(MASTER_DATA_WIDTH/SLAVE_DATA_WIDTH)-1:0] i_info_offset,
    input  logic [LENGTH_WIDTH-1:0]                             i_info_length,
    input  logic                                                i_info_read,
    input  logic                                                i_resp_valid,
    output logic                                                o_resp_ready,
    input  logic [MASTER_DATA_WIDTH-1:0]                        i_resp_data,
    input  logic                                                i_resp_error,
    input  logic                                                i_resp_last,
    output logic                                                o_resp_valid,
    input  logic                                                i_resp_ready,
    output logic [SLAVE_DATA_WIDTH-1:0]                         o_resp_data,
    output logic                                                o_resp_error,
    output logic                                                o_resp_last,
    output logic                                                o_length_error
);
    localparam int RATIO = calc_ratio(MASTER_DATA_WIDTH, SLAVE_DATA_WIDTH);
    localparam int OW    = $clog2(RATIO);

    typedef struct packed {
        logic [OW-1:0]           offset;
        logic [LENGTH_WIDTH-1:0] length;
        logic                    read;
    } pzcorebus_unpack_info;

    localparam int IW = $bits(pzcorebus_unpack_info);

    pzcorebus_unpack_info w_push_info;
    pzcorebus_unpack_info w_info;
    pzcorebus_unpack_info w_next_info;
    logic [IW-1:0]        w_head_bits;
    logic [IW-1:0]        w_next_bits;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic                 w_pop;

    unpack_state_e                           r_state;
    logic [RATIO-1:0][SLAVE_DATA_WIDTH-1:0] r_data;
    logic                                    r_error;
    logic                                    r_last;
    logic [OW-1:0]                           r_lane;
    logic [LENGTH_WIDTH-1:0]                 r_beat;
    logic                                    r_length_error;

    logic          w_hold;
    logic          w_txn_end;
    logic          w_final_lane;
    logic          w_wide_xfer;
    logic          w_narrow_xfer;
    logic [OW-1:0] w_load_lane;

    assign w_push_info = '{offset: i_info_offset, length: i_info_length, read: i_info_read};
    assign w_info      = pzcorebus_unpack_info'(w_head_bits);
    assign w_next_info = pzcorebus_unpack_info'(w_next_bits);

    pzcorebus_response_unpacker_fifo #(
        .WIDTH (IW),
        .DEPTH (INFO_DEPTH)
    ) u_info_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (i_info_valid),
        .i_data  (w_push_info),
        .o_full  (w_fifo_full),
        .i_pop   (w_pop),
        .o_empty (w_fifo_empty),
        .o_data  (w_head_bits),
        .o_next  (w_next_bits)
    );

    assign w_hold        = (r_state == HOLD);
    assign w_txn_end     = !w_info.read || (r_beat == w_info.length);
    assign w_final_lane  = w_txn_end || (r_lane == OW'(RATIO - 1));
    assign w_narrow_xfer = w_hold && i_resp_ready;
    assign w_wide_xfer   = i_resp_valid && o_resp_ready;
    assign w_pop         = w_narrow_xfer && w_txn_end;

    // A reload that closes the transaction starts the next one at its own lane
    assign w_load_lane = w_hold ? (w_txn_end ? w_next_info.offset : '0)
                                : ((r_beat == '0) ? w_info.offset : '0);

    assign o_info_ready   = !w_fifo_full;
    assign o_resp_ready   = w_hold ? (w_final_lane && i_resp_ready) : !w_fifo_empty;
    assign o_resp_valid   = w_hold;
    assign o_resp_data    = (w_hold && w_info.read) ? r_data[r_lane] : '0;
    assign o_resp_error   = w_hold && r_error;
    assign o_resp_last    = w_hold && w_txn_end;
    assign o_length_error = r_length_error;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= EMPTY;
            r_data         <= '0;
            r_error        <= 1'b0;
            r_last         <= 1'b0;
            r_lane         <= '0;
            r_beat         <= '0;
            r_length_error <= 1'b0;
        end else begin
            if (w_wide_xfer) begin
                r_data  <= i_resp_data;
                r_error <= i_resp_error;
                r_last  <= i_resp_last;
            end
            unique case (r_state)
                EMPTY: begin
                    if (w_wide_xfer) begin
                        r_state <= HOLD;
                        r_lane  <= w_load_lane;
                    end
                end
                HOLD: begin
                    if (w_narrow_xfer) begin
                        r_beat <= w_txn_end ? '0 : r_beat + 1'b1;
                        if (!w_final_lane) begin
                            r_lane <= r_lane + 1'b1;
                        end else begin
                            r_length_error <= r_length_error | (w_txn_end != r_last);
                            r_lane         <= w_wide_xfer ? w_load_lane : '0;
                            if (!w_wide_xfer) begin
                                r_state <= EMPTY;
                            end
                        end
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_pzcorebus_response_unpacker.sv
// Self-checking bench for the corebus response unpacker.
// Expected narrow beats come from a lane-position model of each transaction.
module tb_pzcorebus_response_unpacker;
    localparam int SDW = 64;
    localparam int MDW = 256;
    localparam int R   = 4;
    localparam int LW  = 8;

    logic           i_clk = 1'b0;
    logic           i_rst = 1'b1;
    logic           i_info_valid = 1'b0;
    logic           o_info_ready;
    logic [1:0]     i_info_offset = '0;
    logic [LW-1:0]  i_info_length = '0;
    logic           i_info_read = 1'b0;
    logic           i_resp_valid = 1'b0;
    logic           o_resp_ready;
    logic [MDW-1:0] i_resp_data = '0;
    logic           i_resp_error = 1'b0;
    logic           i_resp_last = 1'b0;
    logic           o_resp_valid;
    logic           i_resp_ready = 1'b0;
    logic [SDW-1:0] o_resp_data;
    logic           o_resp_error;
    logic           o_resp_last;
    logic           o_length_error;

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    pzcorebus_response_unpacker #(
        .SLAVE_DATA_WIDTH  (SDW),
        .MASTER_DATA_WIDTH (MDW),
        .LENGTH_WIDTH      (LW),
        .INFO_DEPTH        (4)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_info_valid   (i_info_valid),
        .o_info_ready   (o_info_ready),
        .i_info_offset  (i_info_offset),
        .i_info_length  (i_info_length),
        .i_info_read    (i_info_read),
        .i_resp_valid   (i_resp_valid),
        .o_resp_ready   (o_resp_ready),
        .i_resp_data    (i_resp_data),
        .i_resp_error   (i_resp_error),
        .i_resp_last    (i_resp_last),
        .o_resp_valid   (o_resp_valid),
        .i_resp_ready   (i_resp_ready),
        .o_resp_data    (o_resp_data),
        .o_resp_error   (o_resp_error),
        .o_resp_last    (o_resp_last),
        .o_length_error (o_length_error)
    );

    int             t_off[$];
    int             t_len[$];
    bit             t_rd[$];
    logic [MDW-1:0] w_data[$];
    bit             w_err[$];
    bit             w_last[$];
    logic [SDW-1:0] e_data[$];
    bit             e_err[$];
    bit             e_last[$];
    bit             exp_lerr;
    logic [SDW-1:0] ob_data[$];
    logic           ob_err[$];
    logic           ob_last[$];
    logic           ob_rdy[$];
    logic           ob_lerr[$];
    int             ob_cyc[$];
    int             wacc[$];
    bit             done;
    bit             timeout;
    int             stall_err;

    function automatic logic [MDW-1:0] rnd_wide();
        logic [MDW-1:0] r;
        for (int i = 0; i < MDW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic clear_all();
        t_off.delete(); t_len.delete(); t_rd.delete();
        w_data.delete(); w_err.delete(); w_last.delete();
        e_data.delete(); e_err.delete(); e_last.delete();
        exp_lerr = 1'b0;
    endtask

    // err_mode < 0 picks a random error bit per wide beat
    task automatic add_txn(input int off, input int len, input bit rd,
                           input int err_mode, input bit bad_last);
        int nw;
        nw = rd ? (off + len) / R + 1 : 1;
        t_off.push_back(off); t_len.push_back(len); t_rd.push_back(rd);
        for (int j = 0; j < nw; j++) begin
            w_data.push_back(rnd_wide());
            w_err.push_back(err_mode < 0 ? bit'($urandom % 2) : bit'(err_mode));
            w_last.push_back((j == nw - 1) ^ bad_last);
        end
    endtask

    // Narrow beat k of a read sits at absolute lane position offset+k
    task automatic build_expected();
        int base = 0;
        for (int i = 0; i < t_off.size(); i++) begin
            int nw;
            logic [MDW-1:0] tmp;
            nw = t_rd[i] ? (t_off[i] + t_len[i]) / R + 1 : 1;
            if (t_rd[i]) begin
                for (int k = 0; k <= t_len[i]; k++) begin
                    int p = t_off[i] + k;
                    tmp = w_data[base + p / R];
                    e_data.push_back(tmp[(p % R) * SDW +: SDW]);
                    e_err.push_back(w_err[base + p / R]);
                    e_last.push_back(k == t_len[i]);
                end
            end else begin
                e_data.push_back('0);
                e_err.push_back(w_err[base]);
                e_last.push_back(1'b1);
            end
            for (int j = 0; j < nw; j++)
                if (w_last[base + j] != (j == nw - 1)) exp_lerr = 1'b1;
            base += nw;
        end
    endtask

    // mode 0: ready held, 1: random, 2: repeating 1,0,0,1
    task automatic run(input int mode, input int gap, input int n_stop, input int budget);
        ob_data.delete(); ob_err.delete(); ob_last.delete();
        ob_rdy.delete(); ob_lerr.delete(); ob_cyc.delete(); wacc.delete();
        done = 1'b0; timeout = 1'b0; stall_err = 0;
        fork
            begin : info_drv
                for (int i = 0; i < t_off.size(); i++) begin
                    if (done) break;
                    i_info_valid  = 1'b1;
                    i_info_offset = 2'(t_off[i]);
                    i_info_length = LW'(t_len[i]);
                    i_info_read   = t_rd[i];
                    forever begin
                        @(negedge i_clk);
                        if (o_info_ready || done) break;
                    end
                    @(posedge i_clk); #1;
                    i_info_valid = 1'b0;
                end
            end
            begin : wide_drv
                for (int i = 0; i < w_data.size(); i++) begin
                    while ($urandom_range(0, 99) < gap && !done) begin
                        @(posedge i_clk); #1;
                    end
                    if (done) break;
                    i_resp_valid = 1'b1;
                    i_resp_data  = w_data[i];
                    i_resp_error = w_err[i];
                    i_resp_last  = w_last[i];
                    forever begin
                        @(negedge i_clk);
                        if (o_resp_ready || done) break;
                    end
                    @(posedge i_clk); #1;
                    i_resp_valid = 1'b0;
                end
            end
            begin : mon
                int c = 0;
                bit pv = 1'b0;
                logic [SDW-1:0] pd = '0;
                logic pe = 1'b0;
                logic pl = 1'b0;
                while (ob_data.size() < n_stop && c < budget) begin
                    @(posedge i_clk); #1;
                    case (mode)
                        0: i_resp_ready = 1'b1;
                        1: i_resp_ready = ($urandom_range(0, 3) != 0);
                        default: i_resp_ready = (c % 4 == 0) || (c % 4 == 3);
                    endcase
                    c++;
                    @(negedge i_clk);
                    if (i_resp_valid && o_resp_ready) wacc.push_back(cyc);
                    if (pv && (!o_resp_valid || o_resp_data !== pd ||
                               o_resp_error !== pe || o_resp_last !== pl))
                        stall_err++;
                    if (o_resp_valid && i_resp_ready) begin
                        ob_data.push_back(o_resp_data);
                        ob_err.push_back(o_resp_error);
                        ob_last.push_back(o_resp_last);
                        ob_rdy.push_back(o_resp_ready);
                        ob_lerr.push_back(o_length_error);
                        ob_cyc.push_back(cyc);
                    end
                    pv = o_resp_valid && !i_resp_ready;
                    pd = o_resp_data; pe = o_resp_error; pl = o_resp_last;
                end
                timeout = (ob_data.size() < n_stop);
                @(posedge i_clk); #1;
                i_resp_ready = 1'b0;
                done = 1'b1;
            end
        join
        i_info_valid = 1'b0;
        i_resp_valid = 1'b0;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        i_info_valid = 1'b0; i_resp_valid = 1'b0; i_resp_ready = 1'b0;
        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge i_clk);
        n_checks++;
        if (o_resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", o_resp_valid); end
        n_checks++;
        if (o_info_ready !== 1'b1) begin n_fail++; $display("FAIL reset_info_ready got %b want 1", o_info_ready); end
        n_checks++;
        if (o_resp_ready !== 1'b0) begin n_fail++; $display("FAIL reset_resp_ready got %b want 0", o_resp_ready); end
        n_checks++;
        if ({o_resp_data, o_resp_error, o_resp_last, o_length_error} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got data=%h err=%b last=%b lerr=%b want all 0",
                     o_resp_data, o_resp_error, o_resp_last, o_length_error);
        end
        i_resp_valid = 1'b1;
        i_resp_data  = rnd_wide();
        @(negedge i_clk);
        n_checks++;
        if (o_resp_ready !== 1'b0) begin n_fail++; $display("FAIL no_info_accept got %b want 0", o_resp_ready); end
        @(negedge i_clk);
        n_checks++;
        if (o_resp_valid !== 1'b0) begin n_fail++; $display("FAIL no_info_valid got %b want 0", o_resp_valid); end
        @(posedge i_clk); #1;
        i_resp_valid = 1'b0;
    endtask

    task automatic test_read_basic();
        do_reset();
        clear_all();
        add_txn(1, 5, 1'b1, -1, 1'b0);
        build_expected();
        run(0, 0, e_data.size(), 100);
        n_checks++;
        if (timeout) begin n_fail++; $display("FAIL read_timeout got %0d beats want %0d", ob_data.size(), e_data.size()); end
        for (int i = 0; i < e_data.size(); i++) begin
            n_checks++;
            if (ob_data[i] !== e_data[i] || ob_err[i] !== e_err[i] || ob_last[i] !== e_last[i]) begin
                n_fail++;
                $display("FAIL read_beat[%0d] got %h/%b/%b want %h/%b/%b", i,
                         ob_data[i], ob_err[i], ob_last[i], e_data[i], e_err[i], e_last[i]);
            end
            n_checks++;
            if (ob_rdy[i] !== (i == 2 || i == 5)) begin
                n_fail++;
                $display("FAIL read_ready_pulse[%0d] got %b want %b", i, ob_rdy[i], (i == 2 || i == 5));
            end
        end
        n_checks++;
        if (o_length_error !== 1'b0) begin n_fail++; $display("FAIL read_lerr got %b want 0", o_length_error); end
    endtask

    task automatic test_write_ack();
        clear_all();
        add_txn(0, 0, 1'b0, 0, 1'b0);
        add_txn(0, 0, 1'b0, 1, 1'b0);
        add_txn(0, 0, 1'b0, 0, 1'b0);
        build_expected();
        run(1, 20, e_data.size(), 100);
        n_checks++;
        if (timeout) begin n_fail++; $display("FAIL ack_timeout got %0d beats want 3", ob_data.size()); end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (ob_data[i] !== e_data[i] || ob_err[i] !== e_err[i] || ob_last[i] !== e_last[i]) begin
                n_fail++;
                $display("FAIL ack_beat[%0d] got %h/%b/%b want %h/%b/%b", i,
                         ob_data[i], ob_err[i], ob_last[i], e_data[i], e_err[i], e_last[i]);
            end
        end
        n_checks++;
        if (o_length_error !== 1'b0) begin n_fail++; $display("FAIL ack_lerr got %b want 0", o_length_error); end
    endtask

    task automatic test_back_to_back();
        clear_all();
        add_txn(0, 7, 1'b1, -1, 1'b0);
        build_expected();
        run(0, 0, e_data.size(), 100);
        n_checks++;
        if (timeout || wacc.size() != 2) begin
            n_fail++;
            $display("FAIL b2b_count got %0d beats %0d wide want 8 and 2", ob_data.size(), wacc.size());
        end
        n_checks++;
        if (ob_cyc[0] !== wacc[0] + 1) begin n_fail++; $display("FAIL b2b_latency got %0d want %0d", ob_cyc[0], wacc[0] + 1); end
        for (int i = 1; i < 8; i++) begin
            n_checks++;
            if (ob_cyc[i] !== ob_cyc[0] + i) begin
                n_fail++;
                $display("FAIL b2b_bubble[%0d] got cycle %0d want %0d", i, ob_cyc[i], ob_cyc[0] + i);
            end
        end
        n_checks++;
        if (wacc[1] !== ob_cyc[3]) begin n_fail++; $display("FAIL b2b_reload got cycle %0d want %0d", wacc[1], ob_cyc[3]); end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (ob_data[i] !== e_data[i] || ob_last[i] !== e_last[i]) begin
                n_fail++;
                $display("FAIL b2b_beat[%0d] got %h/%b want %h/%b", i, ob_data[i], ob_last[i], e_data[i], e_last[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        clear_all();
        add_txn($urandom_range(0, 3), $urandom_range(4, 11), 1'b1, -1, 1'b0);
        add_txn($urandom_range(0, 3), $urandom_range(0, 6), 1'b1, -1, 1'b0);
        build_expected();
        run(2, 0, e_data.size(), 300);
        n_checks++;
        if (timeout) begin n_fail++; $display("FAIL bp_timeout got %0d beats want %0d", ob_data.size(), e_data.size()); end
        n_checks++;
        if (stall_err != 0) begin n_fail++; $display("FAIL bp_stable got %0d changes want 0", stall_err); end
        n_checks++;
        if (wacc.size() != w_data.size()) begin n_fail++; $display("FAIL bp_wide_count got %0d want %0d", wacc.size(), w_data.size()); end
        for (int j = 1; j < wacc.size(); j++) begin
            int hits = 0;
            for (int i = 0; i < ob_cyc.size(); i++) if (ob_cyc[i] == wacc[j]) hits++;
            n_checks++;
            if (hits != 1) begin n_fail++; $display("FAIL bp_wide_accept[%0d] got cycle %0d with %0d narrow xfers want 1", j, wacc[j], hits); end
        end
        for (int i = 0; i < e_data.size(); i++) begin
            n_checks++;
            if (ob_data[i] !== e_data[i] || ob_err[i] !== e_err[i] || ob_last[i] !== e_last[i]) begin
                n_fail++;
                $display("FAIL bp_beat[%0d] got %h/%b/%b want %h/%b/%b", i,
                         ob_data[i], ob_err[i], ob_last[i], e_data[i], e_err[i], e_last[i]);
            end
        end
    endtask

    task automatic test_mismatch();
        do_reset();
        clear_all();
        add_txn(0, 3, 1'b1, 0, 1'b1);
        build_expected();
        run(0, 0, e_data.size(), 100);
        n_checks++;
        if (timeout) begin n_fail++; $display("FAIL mm_timeout got %0d beats want 4", ob_data.size()); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (ob_lerr[i] !== 1'b0 || ob_data[i] !== e_data[i] || ob_last[i] !== e_last[i]) begin
                n_fail++;
                $display("FAIL mm_beat[%0d] got lerr=%b %h/%b want lerr=0 %h/%b", i,
                         ob_lerr[i], ob_data[i], ob_last[i], e_data[i], e_last[i]);
            end
        end
        n_checks++;
        if (o_length_error !== exp_lerr) begin n_fail++; $display("FAIL mm_rise got %b want %b", o_length_error, exp_lerr); end
        repeat (5) @(posedge i_clk);
        #1;
        n_checks++;
        if (o_length_error !== 1'b1) begin n_fail++; $display("FAIL mm_sticky got %b want 1", o_length_error); end
        do_reset();
        n_checks++;
        if (o_length_error !== 1'b0) begin n_fail++; $display("FAIL mm_clear got %b want 0", o_length_error); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        clear_all();
        add_txn(2, 5, 1'b1, -1, 1'b0);
        build_expected();
        run(0, 0, 2, 100);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (ob_data[i] !== e_data[i]) begin n_fail++; $display("FAIL mid_beat[%0d] got %h want %h", i, ob_data[i], e_data[i]); end
        end
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        n_checks++;
        if (o_resp_valid !== 1'b0 || o_info_ready !== 1'b1 || o_resp_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset got valid=%b info_ready=%b resp_ready=%b want 0/1/0",
                     o_resp_valid, o_info_ready, o_resp_ready);
        end
        @(posedge i_clk); #1;
        clear_all();
        add_txn(3, 4, 1'b1, -1, 1'b0);
        build_expected();
        run(0, 0, e_data.size(), 100);
        n_checks++;
        if (timeout) begin n_fail++; $display("FAIL mid_fresh_timeout got %0d beats want %0d", ob_data.size(), e_data.size()); end
        for (int i = 0; i < e_data.size(); i++) begin
            n_checks++;
            if (ob_data[i] !== e_data[i] || ob_last[i] !== e_last[i]) begin
                n_fail++;
                $display("FAIL mid_fresh[%0d] got %h/%b want %h/%b", i, ob_data[i], ob_last[i], e_data[i], e_last[i]);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        clear_all();
        for (int i = 0; i < 24; i++) begin
            bit rd = bit'($urandom_range(0, 3) != 0);
            add_txn($urandom_range(0, 3), rd ? $urandom_range(0, 9) : 0, rd, -1, 1'b0);
        end
        build_expected();
        run(1, 30, e_data.size(), 3000);
        n_checks++;
        if (timeout) begin n_fail++; $display("FAIL rnd_timeout got %0d beats want %0d", ob_data.size(), e_data.size()); end
        n_checks++;
        if (stall_err != 0) begin n_fail++; $display("FAIL rnd_stable got %0d changes want 0", stall_err); end
        for (int i = 0; i < e_data.size(); i++) begin
            n_checks++;
            if (ob_data[i] !== e_data[i] || ob_err[i] !== e_err[i] || ob_last[i] !== e_last[i]) begin
                n_fail++;
                $display("FAIL rnd_beat[%0d] got %h/%b/%b want %h/%b/%b", i,
                         ob_data[i], ob_err[i], ob_last[i], e_data[i], e_err[i], e_last[i]);
            end
        end
        n_checks++;
        if (o_length_error !== exp_lerr) begin n_fail++; $display("FAIL rnd_lerr got %b want %b", o_length_error, exp_lerr); end
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write_ack();
        test_back_to_back();
        test_backpressure();
        test_mismatch();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
